// File: rtl/pixel_draw_arbiter.sv
// rtl/pixel_draw_arbiter.sv - round-robin arbiter rastering sprite rectangles onto one VGA write port
// Define PDA_CLIP_EN to suppress off-screen pixels; otherwise coordinates wrap to XW/YW bits.
module pixel_draw_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int XW      = 8,
  parameter int YW      = 7,
  parameter int SW      = 4,
  parameter int X_MAX   = 159,
  parameter int Y_MAX   = 119
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*XW-1:0] req_x,
  input  logic [NUM_REQ*YW-1:0] req_y,
  input  logic [NUM_REQ*SW-1:0] req_w,
  input  logic [NUM_REQ*SW-1:0] req_h,
  input  logic [NUM_REQ*3-1:0]  req_colour,
  output logic [NUM_REQ-1:0]    grant,
  output logic [NUM_REQ-1:0]    done,
  output logic                  busy,
  output logic [XW-1:0]         vga_x,
  output logic [YW-1:0]         vga_y,
  output logic [2:0]            vga_colour,
  output logic                  vga_plot
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [XW:0] X_LIM = (XW+1)'(X_MAX);
  localparam logic [YW:0] Y_LIM = (YW+1)'(Y_MAX);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DRAW, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] rr, sel, pick;
  logic          any_req;
  logic [XW-1:0] x0, hold_x;
  logic [YW-1:0] y0, hold_y;
  logic [SW-1:0] w, h, col, row;
  logic [2:0]    colour, hold_colour;
  logic [XW:0]   sum_x;
  logic [YW:0]   sum_y;
  logic          in_range, last_pix;

  // Scan from rr upward with wrap; lowest offset from rr wins.
  always_comb begin : arb
    logic [IW:0] idx;
    idx     = '0;
    pick    = rr;
    any_req = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, rr} + (IW+1)'(k);
      if (idx >= (IW+1)'(NUM_REQ)) idx = idx - (IW+1)'(NUM_REQ);
      if (req[idx[IW-1:0]]) begin
        pick    = idx[IW-1:0];
        any_req = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_req) state_nxt = S_GRANT;
      S_GRANT: state_nxt = S_DRAW;
      S_DRAW:  if (last_pix) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Sums are one bit wider so an off-screen pixel is never mistaken for a wrapped one.
  always_comb begin
    sum_x    = (XW+1)'(x0) + (XW+1)'(col);
    sum_y    = (YW+1)'(y0) + (YW+1)'(row);
    last_pix = (col == w) && (row == h);
`ifdef PDA_CLIP_EN
    in_range = (sum_x <= X_LIM) && (sum_y <= Y_LIM);
`else
    in_range = 1'b1;
`endif
  end

`ifndef PDA_CLIP_EN
  logic unused_clip;
  assign unused_clip = ^{sum_x[XW], sum_y[YW], X_LIM, Y_LIM};
`endif

  always_comb begin
    grant      = '0;
    done       = '0;
    busy       = (state != S_IDLE);
    vga_plot   = 1'b0;
    vga_x      = hold_x;
    vga_y      = hold_y;
    vga_colour = hold_colour;
    case (state)
      S_GRANT: grant[sel] = 1'b1;
      S_DRAW: begin
        if (in_range) begin
          vga_plot   = 1'b1;
          vga_x      = sum_x[XW-1:0];
          vga_y      = sum_y[YW-1:0];
          vga_colour = colour;
        end
      end
      S_DONE:  done[sel] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr          <= '0;
      sel         <= '0;
      x0          <= '0;
      y0          <= '0;
      w           <= '0;
      h           <= '0;
      colour      <= '0;
      col         <= '0;
      row         <= '0;
      hold_x      <= '0;
      hold_y      <= '0;
      hold_colour <= '0;
    end else begin
      hold_x      <= vga_x;
      hold_y      <= vga_y;
      hold_colour <= vga_colour;
      case (state)
        S_IDLE: if (any_req) sel <= pick;
        S_GRANT: begin
          for (int i = 0; i < NUM_REQ; i++) begin
            if (sel == IW'(i)) begin
              x0     <= req_x[i*XW +: XW];
              y0     <= req_y[i*YW +: YW];
              w      <= req_w[i*SW +: SW];
              h      <= req_h[i*SW +: SW];
              colour <= req_colour[i*3 +: 3];
            end
          end
          col <= '0;
          row <= '0;
        end
        S_DRAW: begin
          if (col == w) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        S_DONE: rr <= (sel == IW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_draw_arbiter.sv
// tb/tb_pixel_draw_arbiter.sv - directed-vector bench for pixel_draw_arbiter
// Covers PDA_CLIP_EN when the macro is defined for the build, coordinate wrap otherwise.
module tb_pixel_draw_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic [2:0]  req;
  logic [23:0] req_x;
  logic [20:0] req_y;
  logic [11:0] req_w;
  logic [11:0] req_h;
  logic [8:0]  req_colour;
  logic [2:0]  grant;
  logic [2:0]  done;
  logic        busy;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pixel_draw_arbiter dut (
    .clk(clk), .resetn(resetn), .req(req), .req_x(req_x), .req_y(req_y),
    .req_w(req_w), .req_h(req_h), .req_colour(req_colour), .grant(grant),
    .done(done), .busy(busy), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int i, input logic [7:0] x, input logic [6:0] y,
                      input logic [3:0] w, input logic [3:0] h, input logic [2:0] c);
    req_x[i*8 +: 8]      = x;
    req_y[i*7 +: 7]      = y;
    req_w[i*4 +: 4]      = w;
    req_h[i*4 +: 4]      = h;
    req_colour[i*3 +: 3] = c;
  endtask

  task automatic pulse_reset();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0; req = 3'b111;
    req_x = '0; req_y = '0; req_w = '0; req_h = '0; req_colour = '0;
    repeat (3) step();
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_plot", vga_plot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_x", vga_x, 0);
    req = 3'b000; resetn = 1'b1;
    step();

    // single 1x4 rectangle on requester 0
    load(0, 8'd2, 7'd54, 4'd0, 4'd3, 3'd7);
    req = 3'b001;
    step();
    chk("single_grant", grant, 3'b001);
    chk("single_busy", busy, 1);
    chk("single_noplot_grant", vga_plot, 0);
    step();
    req = 3'b000;
    load(0, 8'd99, 7'd9, 4'd5, 4'd5, 3'd1);
    for (int r = 0; r < 4; r++) begin
      chk("single_plot", vga_plot, 1);
      chk("single_x", vga_x, 2);
      chk("single_y", vga_y, 54 + r);
      chk("single_colour", vga_colour, 7);
      chk("single_nodone", done, 0);
      step();
    end
    chk("single_done", done, 3'b001);
    chk("single_done_plot", vga_plot, 0);
    chk("single_done_busy", busy, 1);
    chk("single_hold_y", vga_y, 57);
    step();
    chk("single_idle_busy", busy, 0);
    chk("single_idle_done", done, 0);

    // fairness with all three requesting 1x1 rectangles
    pulse_reset();
    for (int i = 0; i < 3; i++) load(i, 8'(10 + 20 * i), 7'(5 + i), 4'd0, 4'd0, 3'(i + 1));
    req = 3'b111;
    step();
    for (int n = 0; n < 6; n++) begin
      chk("fair_grant", grant, 32'(1) << (n % 3));
      step();
      chk("fair_plot", vga_plot, 1);
      chk("fair_x", vga_x, 10 + 20 * (n % 3));
      chk("fair_colour", vga_colour, (n % 3) + 1);
      step();
      chk("fair_done", done, 32'(1) << (n % 3));
      chk("fair_done_grant", grant, 0);
      step();
      chk("fair_idle_busy", busy, 0);
      if (n == 5) req = 3'b000;
      step();
    end
    chk("fair_quiet", busy, 0);

    // rr now 0; requester 1 alone is granted, afterwards rr points at 2
`ifdef PDA_CLIP_EN
    load(1, 8'd158, 7'd118, 4'd3, 4'd1, 3'd6);
    req = 3'b010;
    step();
    chk("clip_grant", grant, 3'b010);
    step();
    req = 3'b000;
    for (int p = 0; p < 8; p++) begin
      chk("clip_plot", vga_plot, ((p % 4) < 2) ? 1 : 0);
      chk("clip_x", vga_x, ((p % 4) < 2) ? 158 + (p % 4) : 159);
      chk("clip_y", vga_y, 118 + p / 4);
      step();
    end
    chk("clip_done", done, 3'b010);
    step();
`else
    load(1, 8'd158, 7'd10, 4'd3, 4'd0, 3'd5);
    req = 3'b010;
    step();
    chk("wrap_grant", grant, 3'b010);
    step();
    req = 3'b000;
    for (int c = 0; c < 4; c++) begin
      chk("wrap_plot", vga_plot, 1);
      chk("wrap_x", vga_x, 158 + c);
      chk("wrap_y", vga_y, 10);
      chk("wrap_colour", vga_colour, 5);
      step();
    end
    chk("wrap_done", done, 3'b010);
    chk("wrap_hold_x", vga_x, 161);
    step();
`endif

    // abort a 16x16 draw on requester 2 at its third pixel
    load(2, 8'd0, 7'd0, 4'd15, 4'd15, 3'd3);
    load(0, 8'd40, 7'd40, 4'd0, 4'd0, 3'd2);
    req = 3'b101;
    step();
    chk("abort_rr_grant", grant, 3'b100);
    step();
    step();
    step();
    chk("abort_third_x", vga_x, 2);
    chk("abort_third_plot", vga_plot, 1);
    resetn = 1'b0;
    #1;
    chk("abort_plot", vga_plot, 0);
    chk("abort_busy", busy, 0);
    chk("abort_x", vga_x, 0);
    chk("abort_colour", vga_colour, 0);
    chk("abort_grant", grant, 0);
    chk("abort_done", done, 0);
    step();
    chk("abort_done_held", done, 0);
    resetn = 1'b1;
    step();
    chk("post_abort_grant", grant, 3'b001);
    step();
    req = 3'b000;
    chk("post_abort_x", vga_x, 40);
    chk("post_abort_y", vga_y, 40);
    chk("post_abort_colour", vga_colour, 2);
    step();
    chk("post_abort_done", done, 3'b001);
    step();
    chk("post_abort_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
